// File: rtl/morse_pkg.sv
// Shared definitions for the Morse element detector: element codes,
// FSM state encoding, default timing and a saturating increment helper.
package morse_pkg;

  // Nominal dot length in clk cycles when the parent does not override it.
  localparam int unsigned DOT_TIME_DEFAULT = 1000000;

  // Element codes as delivered on elem_code.
  typedef enum logic [1:0] {
    ELEM_DOT  = 2'b00,
    ELEM_DASH = 2'b01,
    ELEM_LGAP = 2'b10,
    ELEM_WGAP = 2'b11
  } elem_code_t;

  // Element-timing FSM states.
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    MARK       = 2'b01,
    GAP_SHORT  = 2'b10,
    GAP_LETTER = 2'b11
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/morse_elem_fifo.sv
// Small registered FIFO for detected elements. No fall-through: a pushed
// entry is visible on head/valid from the cycle after the push. A push into
// a full FIFO is accepted only when a pop happens in the same cycle;
// otherwise it is dropped and the sticky overflow flag is set.
module morse_elem_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the simultaneous pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);

  assign valid = !empty;
  assign head  = empty ? '0 : mem[rd_ptr];

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_element_detector.sv
// Morse key element detector: synchronizes and debounces the raw key,
// times marks and spaces against DOT_TIME, and queues dot / dash /
// letter-gap / word-gap codes into a 4-entry FIFO for a consumer.
module morse_element_detector
  import morse_pkg::*;
#(
  parameter int unsigned DOT_TIME      = DOT_TIME_DEFAULT,
  parameter int unsigned DEBOUNCE_TIME = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  output logic       key_clean,
  output logic       elem_valid,
  input  logic       elem_ready,
  output logic [1:0] elem_code,
  output logic       overflow
);

  localparam logic [31:0] DASH_MIN = 32'(2 * DOT_TIME);
  localparam logic [31:0] LGAP_AT  = 32'(2 * DOT_TIME);
  localparam logic [31:0] WGAP_AT  = 32'(5 * DOT_TIME);

  logic        sync1;
  logic        sync2;
  logic [31:0] db_cnt;

  state_t      state;
  state_t      state_n;
  logic [31:0] dur;
  logic [31:0] dur_n;
  logic        push;
  elem_code_t  push_code;

  // Two-flop synchronizer for the asynchronous key input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  // Debounce: adopt the synchronized level only after it has differed from
  // key_clean for DEBOUNCE_TIME consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt    <= '0;
      key_clean <= 1'b0;
    end else if (sync2 == key_clean) begin
      db_cnt <= '0;
    end else if (({1'b0, db_cnt} + 33'd1) >= 33'(DEBOUNCE_TIME)) begin
      db_cnt    <= '0;
      key_clean <= sync2;
    end else begin
      db_cnt <= db_cnt + 32'd1;
    end
  end

  // FSM state and duration counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dur   <= '0;
    end else begin
      state <= state_n;
      dur   <= dur_n;
    end
  end

  // Next-state, duration update and element push decisions.
  always_comb begin
    state_n   = state;
    dur_n     = dur;
    push      = 1'b0;
    push_code = ELEM_DOT;
    case (state)
      IDLE: begin
        if (key_clean) begin
          state_n = MARK;
          dur_n   = 32'd1;
        end
      end
      MARK: begin
        if (key_clean) begin
          dur_n = sat_inc(dur);
        end else begin
          push      = 1'b1;
          push_code = (dur >= DASH_MIN) ? ELEM_DASH : ELEM_DOT;
          state_n   = GAP_SHORT;
          dur_n     = 32'd1;
        end
      end
      GAP_SHORT: begin
        if (key_clean) begin
          state_n = MARK;
          dur_n   = 32'd1;
        end else begin
          dur_n = sat_inc(dur);
          if (dur_n >= LGAP_AT) begin
            push      = 1'b1;
            push_code = ELEM_LGAP;
            state_n   = GAP_LETTER;
          end
        end
      end
      GAP_LETTER: begin
        if (key_clean) begin
          state_n = MARK;
          dur_n   = 32'd1;
        end else begin
          dur_n = sat_inc(dur);
          if (dur_n >= WGAP_AT) begin
            push      = 1'b1;
            push_code = ELEM_WGAP;
            state_n   = IDLE;
            dur_n     = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        dur_n   = '0;
      end
    endcase
  end

  morse_elem_fifo #(
    .DEPTH (4),
    .WIDTH (2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_code),
    .pop       (elem_ready),
    .valid     (elem_valid),
    .head      (elem_code),
    .overflow  (overflow)
  );

endmodule

// File: doc/morse_element_detector.md
MORSE_ELEMENT_DETECTOR -- requirements
Module: morse_element_detector

Interface
REQ-001 The block SHALL have parameter DOT_TIME, default 1000000, giving the nominal dot length in clk cycles.
REQ-002 The block SHALL have parameter DEBOUNCE_TIME, default 50000, giving the stable-input time in clk cycles required before key_clean may change.
REQ-003 Port clk: input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset: input, 1 bit, synchronous, active-high.
REQ-005 Port key_in: input, 1 bit, raw asynchronous Morse key, 1 = key down.
REQ-006 Port key_clean: output, 1 bit, synchronized and debounced key level.
REQ-007 Port elem_valid: output, 1 bit, head of the element FIFO is valid.
REQ-008 Port elem_ready: input, 1 bit, consumer accepts the head element.
REQ-009 Port elem_code: output, 2 bits, head element: 00 dot, 01 dash, 10 letter gap, 11 word gap.
REQ-010 Port overflow: output, 1 bit, sticky flag set when an element was dropped.

Function
REQ-011 key_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 key_clean SHALL take the synchronized value only after that value has differed from key_clean for DEBOUNCE_TIME consecutive cycles; the run counter SHALL clear whenever the synchronized value equals key_clean.
REQ-013 The FSM SHALL have states IDLE, MARK, GAP_SHORT and GAP_LETTER, with one 32-bit duration counter that saturates at all-ones.
REQ-014 IDLE: on key_clean = 1, go to MARK with counter = 1; no gap element is ever produced from IDLE.
REQ-015 MARK: increment the counter while key_clean = 1. On key_clean = 0, push dash if counter >= 2*DOT_TIME, else push dot; then go to GAP_SHORT with counter = 1.
REQ-016 GAP_SHORT: increment the counter while key_clean = 0. When the counter reaches 2*DOT_TIME, push letter gap and go to GAP_LETTER.
REQ-017 GAP_LETTER: keep counting. When the counter reaches 5*DOT_TIME, push word gap and go to IDLE.
REQ-018 In GAP_SHORT or GAP_LETTER, key_clean = 1 SHALL go to MARK with counter = 1 and push nothing.
REQ-019 Pushes SHALL enter a 4-entry FIFO. elem_valid = FIFO not empty. elem_code = head entry. A pop occurs when elem_valid and elem_ready are both high.
REQ-020 A pushed element SHALL appear on elem_valid/elem_code no earlier than the cycle after the push; there is no fall-through.
REQ-021 With the FIFO full, a push without a simultaneous pop SHALL be dropped and SHALL set overflow. A simultaneous push and pop when full SHALL accept the push.
REQ-022 overflow SHALL stay set until reset.
REQ-023 A pop on an empty FIFO SHALL have no effect.
REQ-024 elem_code SHALL be held stable while elem_valid is high and elem_ready is low.

Reset
REQ-025 On reset, the following SHALL be cleared:
- synchronizer flops, debounce counter, key_clean = 0
- FSM = IDLE, duration counter = 0
- FIFO empty, so elem_valid = 0 and elem_code = 00
- overflow = 0
REQ-026 Reset asserted mid-mark or mid-gap SHALL discard the partial element; nothing is pushed for it.

Structure
REQ-027 Shared package morse_pkg SHALL hold:
- element code constants ELEM_DOT, ELEM_DASH, ELEM_LGAP, ELEM_WGAP
- the FSM state encoding
- the default DOT_TIME
REQ-028 The FIFO SHALL be a sub-module morse_elem_fifo, parameterized by depth (4) and width (2).

Verification (DOT_TIME = 10, DEBOUNCE_TIME = 3)
REQ-029 Bounce: key_in toggling every cycle for 20 cycles, then steady at 0 -> key_clean stays 0 and no element is produced.
REQ-030 Dot then dash, elem_ready = 1: key_clean high for 12 cycles, low for 15, high for 25, low for 60. Required elements in order:
- dot
- dash
- letter gap 20 cycles after the second fall
- word gap 50 cycles after the second fall
- nothing further.
REQ-031 Threshold: key_clean high for 19 cycles gives dot; high for 20 cycles gives dash.
REQ-032 Backpressure: with elem_ready = 0, produce 5 dots separated by 15-cycle gaps. Required:
- FIFO holds 4 dots
- overflow = 1 after the fifth
- raising elem_ready drains exactly 4 codes of 00, then elem_valid = 0.
REQ-033 Reset during MARK at cycle 8 -> no element, elem_valid = 0, overflow = 0, FSM = IDLE.
REQ-034 Push and pop when full: with the FIFO full, elem_ready = 1 in the same cycle as a dash push -> overflow stays 0 and the dash is delivered last.
